// File: rtl/onchip_mem_arbiter_if.sv
// Bus bundle between the two requesters (m0 CPU data master, m1 pixel fetcher),
// the arbiter and the single-port on-chip RAM.
interface onchip_mem_arbiter_if;
   // m0: random single-word read/write
   logic [9:0]  m0_address;
   logic [3:0]  m0_byteenable;
   logic        m0_read;
   logic        m0_write;
   logic [31:0] m0_writedata;
   logic        m0_waitrequest;
   logic [31:0] m0_readdata;
   logic        m0_readdatavalid;

   // m1: read-only bursts
   logic [9:0]  m1_address;
   logic [4:0]  m1_burstcount;
   logic        m1_read;
   logic        m1_waitrequest;
   logic [31:0] m1_readdata;
   logic        m1_readdatavalid;

   // RAM s1 side
   logic [9:0]  mem_address;
   logic [3:0]  mem_byteenable;
   logic        mem_chipselect;
   logic        mem_write;
   logic [31:0] mem_writedata;
   logic        mem_clken;
   logic [31:0] mem_readdata;

   // Arbiter view
   modport slave (
      input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
      output m0_waitrequest, m0_readdata, m0_readdatavalid,
      input  m1_address, m1_burstcount, m1_read,
      output m1_waitrequest, m1_readdata, m1_readdatavalid,
      output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
      input  mem_readdata
   );

   // Requester/RAM view
   modport master (
      output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
      input  m0_waitrequest, m0_readdata, m0_readdatavalid,
      output m1_address, m1_burstcount, m1_read,
      input  m1_waitrequest, m1_readdata, m1_readdatavalid,
      input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
      output mem_readdata
   );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// Two-port arbiter for the 1024x32 single-port on-chip RAM. m0 (CPU) gets
// round-robin fairness against m1 burst starts, and a starvation guard lets it
// steal one slot from a long m1 burst after MAX_WAIT stalled cycles.
module onchip_mem_arbiter #(
   parameter int unsigned MAX_BURST = 16,
   parameter int unsigned MAX_WAIT  = 4
) (
   input logic                 clk,
   input logic                 reset_n,
   onchip_mem_arbiter_if.slave bus
);

   localparam int unsigned     WaitW    = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);
   localparam logic [4:0]      BurstMax = 5'(MAX_BURST);

   typedef enum logic [0:0] {StIdle, StBurst} state_e;

   state_e           state_q, state_d;
   logic [4:0]       remaining_q, remaining_d;
   logic [9:0]       next_addr_q, next_addr_d;
   logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
   logic             last_grant_q, last_grant_d;  // 1: m1 won last
   logic             rd_valid_q, rd_valid_d;
   logic             rd_tag_q, rd_tag_d;          // 1: read belongs to m1

   logic       req_m0, req_m1;
   logic       grant_m0, grant_m1, burst_issue;
   logic [4:0] burst_len;

   // Effective burst length: 0 means 1, oversize clamps to MAX_BURST
   always_comb begin
      burst_len = bus.m1_burstcount;
      if (bus.m1_burstcount == 5'd0) begin
         burst_len = 5'd1;
      end else if (bus.m1_burstcount > BurstMax) begin
         burst_len = BurstMax;
      end
   end

   // Grant decision: at most one RAM access per cycle, nothing while in reset
   always_comb begin
      grant_m0    = 1'b0;
      grant_m1    = 1'b0;
      burst_issue = 1'b0;
      req_m0      = bus.m0_read | bus.m0_write;
      req_m1      = bus.m1_read;
      if (reset_n) begin
         unique case (state_q)
            StIdle: begin
               if (req_m0 && (!req_m1 || last_grant_q)) begin
                  grant_m0 = 1'b1;
               end else if (req_m1) begin
                  grant_m1 = 1'b1;
               end
            end
            StBurst: begin
               // Starved CPU preempts exactly one burst slot
               if (req_m0 && (wait_cnt_q == WaitMax)) begin
                  grant_m0 = 1'b1;
               end else begin
                  burst_issue = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Next-state: burst tracking, fairness, starvation counter, read tag
   always_comb begin
      state_d      = state_q;
      remaining_d  = remaining_q;
      next_addr_d  = next_addr_q;
      wait_cnt_d   = wait_cnt_q;
      last_grant_d = last_grant_q;

      if (grant_m0 || grant_m1) begin
         last_grant_d = grant_m1;
      end

      if (grant_m1) begin
         remaining_d = burst_len - 5'd1;
         next_addr_d = bus.m1_address + 10'd1;
         state_d     = (burst_len > 5'd1) ? StBurst : StIdle;
      end

      if (burst_issue) begin
         next_addr_d = next_addr_q + 10'd1;  // wraps 0x3FF -> 0x000
         remaining_d = remaining_q - 5'd1;
         if (remaining_q == 5'd1) begin
            state_d = StIdle;
         end
      end

      if (grant_m0) begin
         wait_cnt_d = '0;
      end else if (req_m0 && reset_n && (wait_cnt_q != WaitMax)) begin
         wait_cnt_d = wait_cnt_q + 1'b1;
      end

      rd_valid_d = (grant_m0 && bus.m0_read) || grant_m1 || burst_issue;
      rd_tag_d   = ~grant_m0;
   end

   // Outputs: granted command steers the RAM port combinationally
   always_comb begin
      bus.m0_waitrequest   = ~grant_m0;
      bus.m1_waitrequest   = ~grant_m1;
      bus.m0_readdata      = bus.mem_readdata;
      bus.m1_readdata      = bus.mem_readdata;
      bus.m0_readdatavalid = rd_valid_q & ~rd_tag_q;
      bus.m1_readdatavalid = rd_valid_q & rd_tag_q;
      bus.mem_clken        = reset_n;
      bus.mem_address      = '0;
      bus.mem_byteenable   = '0;
      bus.mem_chipselect   = 1'b0;
      bus.mem_write        = 1'b0;
      bus.mem_writedata    = '0;
      if (grant_m0) begin
         bus.mem_address    = bus.m0_address;
         bus.mem_byteenable = bus.m0_byteenable;
         bus.mem_chipselect = 1'b1;
         bus.mem_write      = bus.m0_write;
         bus.mem_writedata  = bus.m0_writedata;
      end else if (grant_m1) begin
         bus.mem_address    = bus.m1_address;
         bus.mem_byteenable = 4'hF;
         bus.mem_chipselect = 1'b1;
      end else if (burst_issue) begin
         bus.mem_address    = next_addr_q;
         bus.mem_byteenable = 4'hF;
         bus.mem_chipselect = 1'b1;
      end
   end

   // State registers; reset abandons any burst and drops pending read data
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         remaining_q  <= '0;
         next_addr_q  <= '0;
         wait_cnt_q   <= '0;
         last_grant_q <= 1'b1;
         rd_valid_q   <= 1'b0;
         rd_tag_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         remaining_q  <= remaining_d;
         next_addr_q  <= next_addr_d;
         wait_cnt_q   <= wait_cnt_d;
         last_grant_q <= last_grant_d;
         rd_valid_q   <= rd_valid_d;
         rd_tag_q     <= rd_tag_d;
      end
   end

endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Shares the single-port 1024x32 on-chip RAM between two requesters:
  - m0: the Nios II data master (random single-word read/write).
  - m1: the LVDS display pixel fetcher (read-only bursts).
- Sits between the Avalon interconnect and the on-chip memory s1 port.
- Issues at most one memory access per cycle.
- Guarantees bounded CPU latency during long display bursts.

Parameters:
- MAX_BURST, 16, largest m1 burst length in words.
- MAX_WAIT, 4, cycles m0 may stall during an m1 burst before it preempts one slot.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- m0_address  in  10  word address
- m0_byteenable  in  4  byte lanes for writes
- m0_read  in  1  read request
- m0_write  in  1  write request; m0_read and m0_write are never both high
- m0_writedata  in  32  write data
- m0_waitrequest  out  1  command not accepted this cycle
- m0_readdata  out  32  read data
- m0_readdatavalid  out  1  m0_readdata valid
- m1_address  in  10  burst base word address
- m1_burstcount  in  5  burst length
- m1_read  in  1  burst read request
- m1_waitrequest  out  1  command not accepted this cycle
- m1_readdata  out  32  read data
- m1_readdatavalid  out  1  m1_readdata valid
- mem_address  out  10  to RAM address
- mem_byteenable  out  4  to RAM byteenable
- mem_chipselect  out  1  to RAM chipselect
- mem_write  out  1  to RAM write
- mem_writedata  out  32  to RAM writedata
- mem_clken  out  1  RAM clock enable
- mem_readdata  in  32  from RAM; valid one cycle after a read is issued

Behaviour:
- Reset (reset_n low, asynchronous):
  - State goes to IDLE; burst counter, wait_cnt and read-tag flops clear; last_grant goes to m1, so m0 wins the first tie.
  - Forced outputs: m0_waitrequest=1, m1_waitrequest=1, both readdatavalid=0, mem_chipselect=0, mem_write=0, mem_clken=0.
  - Out of reset, mem_clken is constant 1.
- Issue and accept:
  - Exactly one requester is granted per cycle, or none.
  - The granted command drives the mem_* outputs combinationally in the same cycle, with mem_chipselect=1.
  - A command is accepted when its request is high and its waitrequest is low.
  - waitrequest is high whenever that port is not granted.
- Read latency:
  - A 1-bit tag flop records which port issued the read.
  - The next cycle raises that port's readdatavalid for one cycle, with readdata = mem_readdata.
  - Writes produce no readdatavalid.
  - Both m0_readdata and m1_readdata fan out from mem_readdata.
- States:
  - IDLE: no burst active.
    - Only m0 requesting: grant m0.
    - Only m1 requesting: grant m1; word 0 is issued at m1_address in the accept cycle.
    - Both requesting: grant the port not in last_grant.
    - last_grant updates on every accept.
    - After an m1 accept: remaining = len-1, next_addr = base+1; go to BURST if remaining>0, else stay in IDLE.
  - BURST: m1 owns the RAM and m1_waitrequest=1 for new commands.
    - Each cycle without preemption issues a read at next_addr; next_addr increments modulo 1024 (0x3FF wraps to 0x000) and remaining decrements.
    - The cycle that issues the last word returns the block to IDLE, and a new m1 command can be accepted the following cycle.
- Burst length:
  - m1_burstcount 0 is treated as 1.
  - Values above MAX_BURST are clamped to MAX_BURST.
- Starvation guard:
  - wait_cnt increments on each cycle m0 requests with m0_waitrequest=1; it saturates at MAX_WAIT and clears on m0 accept.
  - In BURST with wait_cnt==MAX_WAIT, m0 is granted for that single cycle: the burst pauses one cycle and resumes the next with address and count unchanged.
- Ordering and hazards:
  - Data on each port returns in issue order.
  - An m0 write followed by any read of the same address in a later cycle returns the new data.
- Reset mid-operation: the active burst is abandoned, any readdatavalid due next cycle is dropped, and no stale issue occurs after reset release.

Test Plan:
- Reset release; m0 write 0x005=0xDEADBEEF with be=0xF, then m0 read 0x005 -> both accepted with waitrequest=0, and m0_readdatavalid=1 with data 0xDEADBEEF exactly one cycle after the read.
- m1 burst at address 0x3FE, burstcount 4, m0 idle -> mem_address sequence 0x3FE, 0x3FF, 0x000, 0x001 on 4 consecutive cycles; 4 consecutive m1_readdatavalid; a second m1 command is held with waitrequest=1 until the cycle after 0x001.
- MAX_WAIT=4; 16-word m1 burst; m0 read asserted in burst cycle 2 -> m0_waitrequest=1 for 4 cycles, granted on the 5th; the burst takes 17 cycles; m1 data is contiguous in order and m0 data is correct.
- After reset, m0 read and m1 command in the same cycle -> m0 granted first; on the next tie m1 is granted.
- m1_burstcount=0 -> exactly 1 word; m1_burstcount=20 -> exactly 16 words.
- reset_n asserted after the third word of an 8-word burst -> valids go 0 and mem_chipselect goes 0 immediately, and no further readdatavalid appears; after release, a new 2-word burst completes normally.
